// File: rtl/addarb.sv
// Two-requester round-robin front end for a shared external N-bit adder.
// Each transaction: IDLE (grant, latch operands) -> EXEC (capture sum) -> DONE (hold until owner ACK).
module addarb #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req0,
    input  logic         req1,
    input  logic         sub0,
    input  logic         sub1,
    input  logic [N-1:0] a0,
    input  logic [N-1:0] b0,
    input  logic [N-1:0] a1,
    input  logic [N-1:0] b1,
    input  logic         ack0,
    input  logic         ack1,
    output logic         gnt0,
    output logic         gnt1,
    output logic         vld0,
    output logic         vld1,
    output logic [N-1:0] add_a,
    output logic [N-1:0] add_b,
    output logic         add_cin,
    input  logic [N-1:0] add_sum,
    input  logic         add_cout,
    input  logic         add_ovf,
    output logic [N-1:0] res,
    output logic         co,
    output logic         ov,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DONE
    } state_t;

    state_t state;
    logic   owner;
    logic   last;
    logic   win_sub;
    logic [N-1:0] win_a;
    logic [N-1:0] win_b;

    // Grant is decided in the IDLE cycle itself so the winner samples its operands
    // on the same edge; gated by reset so nothing is granted while reset is held.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!reset && state == IDLE) begin
            if (req0 && (!req1 || last)) begin
                gnt0 = 1'b1;
            end else if (req1) begin
                gnt1 = 1'b1;
            end
        end
    end

    always_comb begin
        win_sub = gnt1 ? sub1 : sub0;
        win_a   = gnt1 ? a1 : a0;
        win_b   = gnt1 ? b1 : b0;
    end

    assign busy = (state != IDLE);
    assign vld0 = (state == DONE) && !owner;
    assign vld1 = (state == DONE) && owner;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            owner   <= 1'b0;
            last    <= 1'b1;
            add_a   <= '0;
            add_b   <= '0;
            add_cin <= 1'b0;
            res     <= '0;
            co      <= 1'b0;
            ov      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt0 || gnt1) begin
                        owner   <= gnt1;
                        last    <= gnt1;
                        add_a   <= win_a;
                        // Subtraction is A + ~B + 1 through the same adder.
                        add_b   <= win_sub ? ~win_b : win_b;
                        add_cin <= win_sub;
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    res   <= add_sum;
                    co    <= add_cout;
                    ov    <= add_ovf;
                    state <= DONE;
                end
                DONE: begin
                    if (owner ? ack1 : ack0) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/addarb.md
ADDARB -- requirements
Module: addarb

Interface
REQ-001 SHALL have parameter N, default 32, operand/result width in bits.
REQ-002 SHALL have port CLK  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port RESET  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports REQ0/REQ1  input  1  requester 0/1 operation request; held until granted.
REQ-005 SHALL have ports SUB0/SUB1  input  1  requester op select: 0 = A+B, 1 = A-B.
REQ-006 SHALL have ports A0/B0, A1/B1  input  N  requester operands; sampled only in grant cycle.
REQ-007 SHALL have ports ACK0/ACK1  input  1  requester accepts presented result.
REQ-008 SHALL have ports GNT0/GNT1  output  1  one-cycle pulse: request accepted, operands sampled.
REQ-009 SHALL have ports VLD0/VLD1  output  1  result valid for requester 0/1.
REQ-010 SHALL have ports ADD_A/ADD_B  output  N  registered operands driven to shared adder.
REQ-011 SHALL have port ADD_CIN  output  1  registered carry-in to shared adder.
REQ-012 SHALL have ports ADD_SUM (N), ADD_COUT (1), ADD_OVF (1)  input  shared adder outputs, combinational from ADD_A/ADD_B/ADD_CIN, settled within one cycle.
REQ-013 SHALL have ports RES (N), CO (1), OV (1)  output  registered result/carry/overflow.
REQ-014 SHALL have port BUSY  output  1  high whenever state is not IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, EXEC, DONE.
REQ-016 IDLE: if no REQ, stay; else select winner, pulse its GNT, latch operands into ADD_A/ADD_B/ADD_CIN, record owner, go EXEC.
REQ-017 Arbitration SHALL be round-robin via LAST flag: single requester wins; both requesting -> requester != LAST wins.
REQ-018 LAST SHALL update to winner's index in grant cycle.
REQ-019 Add: ADD_A=A, ADD_B=B, ADD_CIN=0; Sub: ADD_A=A, ADD_B=~B, ADD_CIN=1.
REQ-020 EXEC: capture ADD_SUM->RES, ADD_COUT->CO, ADD_OVF->OV; go DONE (exactly one cycle in EXEC).
REQ-021 DONE: assert owner's VLD only (other VLD low); RES/CO/OV stable; stay until owner's ACK high, then go IDLE with VLD deasserted next cycle.
REQ-022 ACK from non-owner, or ACK outside DONE, SHALL be ignored.
REQ-023 GNT SHALL pulse only in IDLE; at most one of GNT0/GNT1 high per cycle; REQs arriving in EXEC/DONE wait.
REQ-024 Grant-to-VLD latency SHALL be 2 cycles (GNT cycle t, VLD high from t+2); minimum request spacing per transaction 3 cycles.
REQ-025 Same-cycle ACK in DONE and new REQ: ACK processed first; new REQ granted no earlier than following IDLE cycle.
REQ-026 RES/CO/OV SHALL hold last captured values outside DONE until next EXEC capture.
REQ-027 Carry/overflow semantics SHALL be exactly those of the shared adder; no local recomputation.

Reset
REQ-028 RESET high SHALL immediately force: state IDLE, LAST=1 (requester 0 wins first tie), GNT0/1=0, VLD0/1=0, BUSY=0, ADD_A=ADD_B=0, ADD_CIN=0, RES=0, CO=0, OV=0.
REQ-029 Reset during EXEC or DONE SHALL discard in-flight operation; no VLD issued after release.
REQ-030 First grant after reset deassertion SHALL occur no earlier than first rising edge with RESET low.

Verification
REQ-031 Single add: N=32, REQ0, A0=5, B0=7, SUB0=0 -> GNT0 at t, VLD0 at t+2, RES=12, CO=0, OV=0; ACK0 -> IDLE.
REQ-032 Subtract/borrow: REQ1, A1=3, B1=5, SUB1=1 -> ADD_B=0xFFFFFFFA, ADD_CIN=1, RES=0xFFFFFFFE, CO=0, OV=0, VLD1 only.
REQ-033 Overflow: A0=0x7FFFFFFF, B0=1, add -> RES=0x80000000, OV=1, CO=0; A0=0xFFFFFFFF, B0=1 -> RES=0, CO=1, OV=0.
REQ-034 Contention: REQ0, REQ1 held high from reset -> grants alternate GNT0, GNT1, GNT0..., each VLD routed to correct owner.
REQ-035 Hold: withhold ACK0 10 cycles -> VLD0 and RES stable, REQ1 not granted, ACK1 ignored; ACK0 -> GNT1 follows.
REQ-036 Mid-op reset: assert RESET in EXEC cycle -> all outputs zero immediately, no VLD after release, next REQ1-only request granted normally.
